// File: rtl/zero_run_cntr.sv
// Multi-channel zero-sample counter: consecutive-run or cumulative count per channel,
// with saturation, threshold flag, run-end pulse and peak-run capture.
module zero_run_cntr #(
    parameter int DATA_W = 7,
    parameter int CNT_W  = 4,
    parameter int N_CH   = 4,
    parameter int THRESH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_CH*DATA_W-1:0] adj_val,
    input  logic                   mode,
    input  logic                   clr,
    output logic [N_CH*CNT_W-1:0]  zCnt,
    output logic [N_CH*CNT_W-1:0]  max_run,
    output logic [N_CH-1:0]        run_flag,
    output logic [N_CH-1:0]        run_end,
    output logic [N_CH-1:0]        sat
);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_THR   = CNT_W'(THRESH);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [N_CH-1:0]   CH_ZERO   = {N_CH{1'b0}};

    // Increment that sticks at the top value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [CNT_W-1:0] cnt_r     [N_CH];
    logic [CNT_W-1:0] max_r     [N_CH];
    logic [N_CH-1:0]  flag_r;
    logic [N_CH-1:0]  end_r;
    logic [N_CH-1:0]  sat_r;

    logic [CNT_W-1:0] cnt_nxt_s [N_CH];
    logic [CNT_W-1:0] max_nxt_s [N_CH];
    logic [N_CH-1:0]  flag_nxt_s;
    logic [N_CH-1:0]  end_nxt_s;
    logic [N_CH-1:0]  sat_nxt_s;
    logic [N_CH-1:0]  zero_s;

    // Per-channel zero detect on the incoming sample slice.
    always_comb begin
        zero_s = CH_ZERO;
        for (int c = 0; c < N_CH; c++) begin
            zero_s[c] = (adj_val[c*DATA_W +: DATA_W] == DATA_ZERO);
        end
    end

    // Next-state for every channel; flag/peak/sticky derive from the next count.
    always_comb begin
        flag_nxt_s = CH_ZERO;
        end_nxt_s  = CH_ZERO;
        sat_nxt_s  = CH_ZERO;
        for (int c = 0; c < N_CH; c++) begin
            cnt_nxt_s[c] = cnt_r[c];
            if (in_valid) begin
                if (zero_s[c]) begin
                    cnt_nxt_s[c] = sat_inc(cnt_r[c]);
                end else if (!mode) begin
                    cnt_nxt_s[c] = CNT_ZERO;
                end else begin
                    cnt_nxt_s[c] = cnt_r[c];
                end
                end_nxt_s[c] = !mode && !zero_s[c] && (cnt_r[c] >= CNT_THR);
            end else begin
                end_nxt_s[c] = 1'b0;
            end
            max_nxt_s[c]  = (cnt_nxt_s[c] > max_r[c]) ? cnt_nxt_s[c] : max_r[c];
            sat_nxt_s[c]  = sat_r[c] | (cnt_nxt_s[c] == CNT_MAX);
            flag_nxt_s[c] = (cnt_nxt_s[c] >= CNT_THR);
        end
    end

    // Channel state registers; clr discards the concurrent sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_r[c] <= CNT_ZERO;
                max_r[c] <= CNT_ZERO;
            end
            flag_r <= CH_ZERO;
            end_r  <= CH_ZERO;
            sat_r  <= CH_ZERO;
        end else if (clr) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_r[c] <= CNT_ZERO;
                max_r[c] <= CNT_ZERO;
            end
            flag_r <= CH_ZERO;
            end_r  <= CH_ZERO;
            sat_r  <= CH_ZERO;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_r[c] <= cnt_nxt_s[c];
                max_r[c] <= max_nxt_s[c];
            end
            flag_r <= flag_nxt_s;
            end_r  <= end_nxt_s;
            sat_r  <= sat_nxt_s;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign zCnt[g*CNT_W +: CNT_W]    = cnt_r[g];
        assign max_run[g*CNT_W +: CNT_W] = max_r[g];
    end

    assign run_flag = flag_r;
    assign run_end  = end_r;
    assign sat      = sat_r;

endmodule
